result_serializer: RTL
======================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter COMPUTE_SLICES, default 4, number of parallel accumulator results captured per transfer.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, width of each signed two's-complement accumulator result.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ena  input  1  advance enable; when low, all state holds.
REQ-006 SHALL have port acc_in  input  COMPUTE_SLICES*ACC_WIDTH  packed results; slice 0 in the LSBs.
REQ-007 SHALL have port acc_valid  input  1  one-cycle request to capture acc_in.
REQ-008 SHALL have port data_out  output  8  current output byte, registered.
REQ-009 SHALL have port data_valid  output  1  data_out holds a valid byte this cycle.
REQ-010 SHALL have port busy  output  1  high while a transfer is draining.
REQ-011 SHALL have port overrun  output  1  sticky flag: a capture request was dropped.

Function
REQ-012 SHALL implement two states: IDLE and DRAIN.
REQ-013 Capture: in IDLE, with acc_valid=1 and ena=1 at a clock edge, the block SHALL register all of acc_in, load byte 0 into data_out, set data_valid=1 and busy=1, and enter DRAIN.
REQ-014 Latency SHALL be 1 cycle: the first byte is valid in the cycle after the capture edge.
REQ-015 Byte order SHALL be slice 0 first, ascending slice index; within a slice, low byte first (full-width mode).
REQ-016 In DRAIN, each edge with ena=1 SHALL advance data_out to the next byte; with ena=0, data_out, the byte counter and the state SHALL hold.
REQ-017 Bytes per transfer B SHALL be 2*COMPUTE_SLICES in full-width mode (ACC_WIDTH bits zero- or sign-padded to 16) or COMPUTE_SLICES in saturate mode.
REQ-018 The byte counter SHALL be $clog2(B) bits wide, SHALL start at 0 on capture, and SHALL never exceed B-1.
REQ-019 On the edge that advances past byte B-1 with acc_valid=0, the block SHALL return to IDLE and clear data_valid and busy.
REQ-020 Back-to-back transfers: acc_valid=1 on the cycle the last byte is presented SHALL be accepted, and byte 0 of the new transfer SHALL follow with no gap cycle.
REQ-021 acc_valid=1 in DRAIN before the last byte SHALL be ignored; the captured data SHALL be unaffected, and overrun SHALL be set to 1.
REQ-022 overrun SHALL remain set until reset.
REQ-023 acc_valid while ena=0 SHALL be ignored and SHALL NOT set overrun.
REQ-024 In IDLE, data_out SHALL hold its last value and data_valid SHALL be 0.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, counter=0, data_out=0x00, data_valid=0, busy=0 and overrun=0, regardless of clk.
REQ-026 Reset during DRAIN SHALL abort the transfer, and no further bytes of it SHALL be emitted.
REQ-027 After rst_n deasserts, the first capture SHALL be possible on the next rising edge.

Configuration
REQ-028 Macro RESULT_SATURATE_EN defined: each result SHALL be emitted as one byte, clamped to the signed range [-128,127] (0x80..0x7F).
REQ-029 Macro RESULT_SATURATE_EN undefined: each result SHALL be emitted as two bytes, sign-extended to 16 bits, with no clamping.

Structure
REQ-030 Package result_serializer_pkg SHALL hold the state enum, the default ACC_WIDTH, and a function returning B from COMPUTE_SLICES and the mode.
REQ-031 One sub-module, sat_int8, SHALL implement the combinational signed ACC_WIDTH to 8-bit clamp, and SHALL be instantiated only when RESULT_SATURATE_EN is defined.
REQ-032 The block SHALL sit directly downstream of the compute slices and SHALL feed uo_out of tt_um_rejunity_1_58bit.

Verification
REQ-033 Full-width mode, COMPUTE_SLICES=2, acc_in={16'hFF85,16'h0123}, single acc_valid pulse -> data_valid for 4 cycles, data_out = 23,01,85,FF, then busy=0.
REQ-034 Saturate mode, slices {+300,-5,-1000,+127} -> data_out = 7F,FB,80,7F, one byte per cycle.
REQ-035 Stall: ena=0 for 3 cycles after byte 1 -> byte 1 held for 3 cycles, sequence otherwise intact, still 4 data_valid advances.
REQ-036 acc_valid during byte 1 of 4 -> original sequence unchanged, overrun=1 and stays 1; acc_valid on byte 3 -> new byte 0 on the next cycle, no gap.
REQ-037 rst_n asserted mid-drain between clock edges -> data_valid=0, busy=0, data_out=00 immediately; a new capture after release emits from byte 0.

Source files
------------

// File: rtl/result_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_serializer_pkg
// Description : Shared types and helpers for the result serializer: FSM state
//               enum, default accumulator width, transfer length helper.
//               Build macro: RESULT_SATURATE_EN (one clamped byte per result
//               instead of two sign-extended bytes).
// Revision    : 1.0 - initial release
// ============================================================================
package result_serializer_pkg;

  localparam int ACC_WIDTH_DEFAULT = 16;

`ifdef RESULT_SATURATE_EN
  localparam bit SAT_MODE = 1'b1;
`else
  localparam bit SAT_MODE = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Bytes emitted per transfer: one per slice when clamping, two otherwise.
  function automatic int bytes_per_transfer(input int slices, input bit sat_mode);
    return sat_mode ? slices : 2 * slices;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : result_serializer_if
// Description : Bus between the compute slices (master) and the serializer
//               (slave).
//   ena        : advance enable, all serializer state holds while low
//   acc_in     : packed results, slice 0 in the LSBs
//   acc_valid  : one-cycle capture request
//   data_out   : registered output byte
//   data_valid : data_out holds a valid byte
//   busy       : transfer draining
//   overrun    : sticky, a capture request was dropped
// Revision    : 1.0 - initial release
// ============================================================================
interface result_serializer_if
  import result_serializer_pkg::*;
#(
  parameter int COMPUTE_SLICES = 4,
  parameter int ACC_WIDTH      = ACC_WIDTH_DEFAULT
);

  logic                                ena;
  logic [COMPUTE_SLICES*ACC_WIDTH-1:0] acc_in;
  logic                                acc_valid;
  logic [7:0]                          data_out;
  logic                                data_valid;
  logic                                busy;
  logic                                overrun;

  modport master (
    output ena, acc_in, acc_valid,
    input  data_out, data_valid, busy, overrun
  );

  modport slave (
    input  ena, acc_in, acc_valid,
    output data_out, data_valid, busy, overrun
  );

endinterface
`default_nettype wire

// File: rtl/sat_int8.sv
`default_nettype none
// ============================================================================
// Module      : sat_int8
// Description : Combinational clamp of a signed ACC_WIDTH value to the signed
//               8-bit range [-128, 127].
//   acc_in  : signed input value
//   sat_out : clamped two's-complement byte
// Revision    : 1.0 - initial release
// ============================================================================
module sat_int8 #(
  parameter int ACC_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  output logic        [7:0]           sat_out
);

  if (ACC_WIDTH <= 8) begin : g_narrow
    // Already inside the byte range; just sign-extend.
    assign sat_out = 8'(acc_in);
  end else begin : g_wide
    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(-128);

    always_comb begin
      if (acc_in > MAX_V) begin
        sat_out = 8'h7F;
      end else if (acc_in < MIN_V) begin
        sat_out = 8'h80;
      end else begin
        sat_out = acc_in[7:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : result_serializer
// Description : Captures COMPUTE_SLICES signed accumulator results in one
//               cycle and drains them as a byte stream, slice 0 first.
//               Full-width build: two bytes per result (low byte first),
//               sign-extended to 16 bits. With RESULT_SATURATE_EN defined:
//               one byte per result, clamped to [-128, 127].
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : result_serializer_if.slave (ena, acc_in, acc_valid in;
//           data_out, data_valid, busy, overrun out)
// Revision    : 1.0 - initial release
// ============================================================================
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int COMPUTE_SLICES = 4,
  parameter int ACC_WIDTH      = ACC_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  result_serializer_if.slave bus
);

  localparam int NUM_BYTES = bytes_per_transfer(COMPUTE_SLICES, SAT_MODE);
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int DATA_W    = COMPUTE_SLICES * ACC_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  state_e            state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic [DATA_W-1:0] data_q,       data_d;
  logic [7:0]        data_out_q,   data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              busy_q,       busy_d;
  logic              overrun_q,    overrun_d;

  logic                       at_last;
  logic                       capture;
  logic [DATA_W-1:0]          byte_src;
  logic [CNT_W-1:0]           byte_idx;
  logic [NUM_BYTES-1:0][7:0]  byte_lane;

  // A new transfer is accepted from IDLE or while the last byte is on the
  // output, which gives gapless back-to-back transfers.
  assign at_last = (state_q == ST_DRAIN) && (cnt_q == LAST_IDX);
  assign capture = bus.ena && bus.acc_valid && ((state_q == ST_IDLE) || at_last);

  // One byte-lane network serves both the capture (byte 0 straight from
  // acc_in) and the drain (next byte from the held copy).
  assign byte_src = capture ? bus.acc_in : data_q;
  assign byte_idx = capture ? '0 : cnt_q + CNT_W'(1);

  for (genvar s = 0; s < COMPUTE_SLICES; s++) begin : g_slice
    logic signed [ACC_WIDTH-1:0] res;
    assign res = byte_src[s*ACC_WIDTH +: ACC_WIDTH];
`ifdef RESULT_SATURATE_EN
    sat_int8 #(
      .ACC_WIDTH (ACC_WIDTH)
    ) u_sat (
      .acc_in  (res),
      .sat_out (byte_lane[s])
    );
`else
    logic signed [15:0] res_ext;
    assign res_ext          = 16'(res);
    assign byte_lane[2*s]   = res_ext[7:0];
    assign byte_lane[2*s+1] = res_ext[15:8];
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;

    if (bus.ena) begin
      if (capture) begin
        state_d      = ST_DRAIN;
        cnt_d        = '0;
        data_d       = bus.acc_in;
        data_out_d   = byte_lane[byte_idx];
        data_valid_d = 1'b1;
        busy_d       = 1'b1;
      end else if (state_q == ST_DRAIN) begin
        if (at_last) begin
          // data_out keeps the last byte while idle.
          state_d      = ST_IDLE;
          cnt_d        = '0;
          data_valid_d = 1'b0;
          busy_d       = 1'b0;
        end else begin
          cnt_d      = byte_idx;
          data_out_d = byte_lane[byte_idx];
          if (bus.acc_valid) begin
            overrun_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire
